// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-cycle RAM.
// Port 0 is the CPU data side and port 1 is the loader/debug side.
// In SHARED state, contended cycles alternate between the two ports.
// In EXCL state, port 1 owns the RAM outright.
// Read data is registered per port, and rvalid follows one cycle after a granted read.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic [1:0]        p0_width,
    input  logic              p0_sext,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_stall,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    input  logic [1:0]        p1_width,
    input  logic              p1_sext,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    input  logic              excl_req,
    output logic              excl_ack,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    output logic [1:0]        ram_width,
    output logic              ram_sext,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic {SHARED, EXCL} state_t;

    state_t            stateReg;
    logic              lastGnt;      // 0 = port 0 won last, 1 = port 1 won last
    logic              exclExit;     // port 0 forced first after leaving EXCL
    logic              exclAckReg;
    logic              p0Gnt;
    logic              p1Gnt;
    logic              p0RvalidReg;
    logic              p1RvalidReg;
    logic [DATA_W-1:0] p0RdataReg;
    logic [DATA_W-1:0] p1RdataReg;

    // Grant decision: nothing during reset, port 1 only in EXCL, round-robin on contention
    always_comb begin
        p0Gnt = 1'b0;
        p1Gnt = 1'b0;
        if (!rst) begin
            if (stateReg == EXCL) begin
                p1Gnt = p1_req;
            end else if (p0_req && p1_req) begin
                if (lastGnt || exclExit) begin
                    p0Gnt = 1'b1;
                end else begin
                    p1Gnt = 1'b1;
                end
            end else begin
                p0Gnt = p0_req;
                p1Gnt = p1_req;
            end
        end
    end

    // RAM drive: the granted port's fields, otherwise port 0 fields with the write disabled
    always_comb begin
        if (p1Gnt) begin
            ram_addr  = p1_addr;
            ram_wdata = p1_wdata;
            ram_width = p1_width;
            ram_sext  = p1_sext;
            ram_we    = p1_we;
        end else begin
            ram_addr  = p0_addr;
            ram_wdata = p0_wdata;
            ram_width = p0_width;
            ram_sext  = p0_sext;
            ram_we    = p0Gnt & p0_we;
        end
    end

    // Ownership FSM plus arbitration history; lastGnt is frozen while in EXCL
    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg   <= SHARED;
            lastGnt    <= 1'b1;
            exclExit   <= 1'b0;
            exclAckReg <= 1'b0;
        end else begin
            case (stateReg)
                SHARED: begin
                    if (p0Gnt) begin
                        lastGnt <= 1'b0;
                    end else if (p1Gnt) begin
                        lastGnt <= 1'b1;
                    end
                    if (p0_req && p1_req) begin
                        exclExit <= 1'b0;
                    end
                    if (excl_req) begin
                        stateReg   <= EXCL;
                        exclAckReg <= 1'b1;
                    end
                end
                EXCL: begin
                    if (!excl_req) begin
                        stateReg   <= SHARED;
                        exclAckReg <= 1'b0;
                        exclExit   <= 1'b1;
                    end
                end
                default: begin
                    stateReg   <= SHARED;
                    exclAckReg <= 1'b0;
                end
            endcase
        end
    end

    // Read return: capture RAM data on a granted read and pulse rvalid for one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            p0RvalidReg <= 1'b0;
            p1RvalidReg <= 1'b0;
            p0RdataReg  <= '0;
            p1RdataReg  <= '0;
        end else begin
            p0RvalidReg <= p0Gnt & ~p0_we;
            p1RvalidReg <= p1Gnt & ~p1_we;
            if (p0Gnt && !p0_we) begin
                p0RdataReg <= ram_rdata;
            end
            if (p1Gnt && !p1_we) begin
                p1RdataReg <= ram_rdata;
            end
        end
    end

    // A read granted just before reset must not report valid data while reset is held
    assign p0_rvalid = p0RvalidReg & ~rst;
    assign p1_rvalid = p1RvalidReg & ~rst;
    assign p0_rdata  = p0RdataReg;
    assign p1_rdata  = p1RdataReg;
    assign p0_gnt    = p0Gnt;
    assign p1_gnt    = p1Gnt;
    assign p0_stall  = p0_req & ~p0Gnt;
    assign excl_ack  = exclAckReg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter.
// A behavioural RAM model sits on the ram_* port.
// Table vectors cover arbitration, RAM drive and read return.
// Hand sequences cover reset, exclusive mode and a reset that aborts a read.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_req, p0_we, p0_sext, p0_gnt, p0_rvalid, p0_stall;
    logic [31:0] p0_addr, p0_wdata, p0_rdata;
    logic [1:0]  p0_width;
    logic        p1_req, p1_we, p1_sext, p1_gnt, p1_rvalid;
    logic [31:0] p1_addr, p1_wdata, p1_rdata;
    logic [1:0]  p1_width;
    logic        excl_req, excl_ack;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic        ram_we, ram_sext;
    logic [1:0]  ram_width;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_width(p0_width), .p0_sext(p0_sext), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid),
        .p0_rdata(p0_rdata), .p0_stall(p0_stall),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_width(p1_width), .p1_sext(p1_sext), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid),
        .p1_rdata(p1_rdata),
        .excl_req(excl_req), .excl_ack(excl_ack),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
        .ram_width(ram_width), .ram_sext(ram_sext), .ram_rdata(ram_rdata)
    );

    // RAM model: combinational read, write on the clock edge, preload while preload is high
    logic        preload;
    logic [31:0] mem [0:63];
    assign ram_rdata = mem[ram_addr[7:2]];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[4] <= 32'hDEADBEEF;   // 0x10
            mem[5] <= 32'hCAFEF00D;   // 0x14
        end else if (ram_we) begin
            mem[ram_addr[7:2]] <= ram_wdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        q0, w0; logic [31:0] a0, d0;
        logic        q1, w1; logic [31:0] a1, d1;
        logic        g0, g1, st, rwe; logic [31:0] raddr;
        logic        rv0, rv1; logic [31:0] rd0, rd1;
    } vec_t;

    vec_t vec [12];

    initial begin
        // Stimulus table: inputs | gnt0 gnt1 stall ram_we ram_addr | rvalid0 rvalid1 rdata0 rdata1
        vec[0]  = '{1'b1,1'b0,32'h10,32'h0,        1'b1,1'b0,32'h14,32'h0,        1'b1,1'b0,1'b0,1'b0,32'h10, 1'b0,1'b0,32'h0,       32'h0};
        vec[1]  = '{1'b1,1'b0,32'h10,32'h0,        1'b1,1'b0,32'h14,32'h0,        1'b0,1'b1,1'b1,1'b0,32'h14, 1'b1,1'b0,32'hDEADBEEF,32'h0};
        vec[2]  = '{1'b1,1'b0,32'h10,32'h0,        1'b1,1'b0,32'h14,32'h0,        1'b1,1'b0,1'b0,1'b0,32'h10, 1'b0,1'b1,32'hDEADBEEF,32'hCAFEF00D};
        vec[3]  = '{1'b1,1'b0,32'h10,32'h0,        1'b1,1'b0,32'h14,32'h0,        1'b0,1'b1,1'b1,1'b0,32'h14, 1'b1,1'b0,32'hDEADBEEF,32'hCAFEF00D};
        vec[4]  = '{1'b0,1'b1,32'h30,32'h0,        1'b0,1'b0,32'h14,32'h0,        1'b0,1'b0,1'b0,1'b0,32'h30, 1'b0,1'b1,32'hDEADBEEF,32'hCAFEF00D};
        vec[5]  = '{1'b0,1'b0,32'h30,32'h0,        1'b1,1'b1,32'h20,32'h12345678, 1'b0,1'b1,1'b0,1'b1,32'h20, 1'b0,1'b0,32'hDEADBEEF,32'hCAFEF00D};
        vec[6]  = '{1'b1,1'b0,32'h20,32'h0,        1'b0,1'b0,32'h20,32'h0,        1'b1,1'b0,1'b0,1'b0,32'h20, 1'b0,1'b0,32'hDEADBEEF,32'hCAFEF00D};
        vec[7]  = '{1'b0,1'b0,32'h20,32'h0,        1'b0,1'b0,32'h20,32'h0,        1'b0,1'b0,1'b0,1'b0,32'h20, 1'b1,1'b0,32'h12345678,32'hCAFEF00D};
        vec[8]  = '{1'b1,1'b1,32'h24,32'hA5A5A5A5, 1'b0,1'b0,32'h20,32'h0,        1'b1,1'b0,1'b0,1'b1,32'h24, 1'b0,1'b0,32'h12345678,32'hCAFEF00D};
        vec[9]  = '{1'b1,1'b0,32'h24,32'h0,        1'b1,1'b0,32'h10,32'h0,        1'b0,1'b1,1'b1,1'b0,32'h10, 1'b0,1'b0,32'h12345678,32'hCAFEF00D};
        vec[10] = '{1'b1,1'b0,32'h24,32'h0,        1'b0,1'b0,32'h10,32'h0,        1'b1,1'b0,1'b0,1'b0,32'h24, 1'b0,1'b1,32'h12345678,32'hDEADBEEF};
        vec[11] = '{1'b0,1'b0,32'h24,32'h0,        1'b0,1'b0,32'h10,32'h0,        1'b0,1'b0,1'b0,1'b0,32'h24, 1'b1,1'b0,32'hA5A5A5A5,32'hDEADBEEF};

        rst = 1'b1; preload = 1'b1; excl_req = 1'b0;
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = 32'h0; p0_wdata = 32'h0; p0_width = 2'b10; p0_sext = 1'b0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = 32'h0; p1_wdata = 32'h0; p1_width = 2'b01; p1_sext = 1'b1;
        step();
        preload = 1'b0;

        // Requests during reset: no grant, no write reaches the RAM
        p0_req = 1'b1; p0_addr = 32'h10;
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'h10; p1_wdata = 32'h00000055;
        #2;
        $display("reset hold: p0_gnt=%0b p1_gnt=%0b ram_we=%0b", p0_gnt, p1_gnt, ram_we);
        chk("rst_p0_gnt", {31'b0, p0_gnt}, 32'd0);
        chk("rst_p1_gnt", {31'b0, p1_gnt}, 32'd0);
        chk("rst_ram_we", {31'b0, ram_we}, 32'd0);
        step();
        $display("after reset: excl_ack=%0b rv0=%0b rv1=%0b rd0=%08h rd1=%08h",
                 excl_ack, p0_rvalid, p1_rvalid, p0_rdata, p1_rdata);
        chk("rst_excl_ack", {31'b0, excl_ack}, 32'd0);
        chk("rst_p0_rvalid", {31'b0, p0_rvalid}, 32'd0);
        chk("rst_p1_rvalid", {31'b0, p1_rvalid}, 32'd0);
        chk("rst_p0_rdata", p0_rdata, 32'h0);
        chk("rst_p1_rdata", p1_rdata, 32'h0);

        // First cycle out of reset: p0 read of 0x10 (write attempted during reset must not have landed)
        rst = 1'b0;
        p1_req = 1'b0; p1_we = 1'b0;
        #2;
        $display("p0 read 0x10: p0_gnt=%0b ram_addr=%08h", p0_gnt, ram_addr);
        chk("rd10_gnt", {31'b0, p0_gnt}, 32'd1);
        chk("rd10_ram_addr", ram_addr, 32'h10);
        step();
        p0_req = 1'b0;
        #2;
        $display("p0 read 0x10 return: rvalid=%0b rdata=%08h", p0_rvalid, p0_rdata);
        chk("rd10_rvalid", {31'b0, p0_rvalid}, 32'd1);
        chk("rd10_rdata", p0_rdata, 32'hDEADBEEF);

        // Fresh reset so the table starts with port 0 holding priority
        rst = 1'b1;
        step();
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            p0_req = vec[i].q0; p0_we = vec[i].w0; p0_addr = vec[i].a0; p0_wdata = vec[i].d0;
            p1_req = vec[i].q1; p1_we = vec[i].w1; p1_addr = vec[i].a1; p1_wdata = vec[i].d1;
            #2;
            $display("vec %0d: gnt=%0b%0b stall=%0b we=%0b addr=%08h rv=%0b%0b rd0=%08h rd1=%08h",
                     i, p0_gnt, p1_gnt, p0_stall, ram_we, ram_addr, p0_rvalid, p1_rvalid, p0_rdata, p1_rdata);
            chk($sformatf("v%0d_p0_gnt", i), {31'b0, p0_gnt}, {31'b0, vec[i].g0});
            chk($sformatf("v%0d_p1_gnt", i), {31'b0, p1_gnt}, {31'b0, vec[i].g1});
            chk($sformatf("v%0d_stall", i), {31'b0, p0_stall}, {31'b0, vec[i].st});
            chk($sformatf("v%0d_ram_we", i), {31'b0, ram_we}, {31'b0, vec[i].rwe});
            chk($sformatf("v%0d_ram_addr", i), ram_addr, vec[i].raddr);
            chk($sformatf("v%0d_p0_rvalid", i), {31'b0, p0_rvalid}, {31'b0, vec[i].rv0});
            chk($sformatf("v%0d_p1_rvalid", i), {31'b0, p1_rvalid}, {31'b0, vec[i].rv1});
            chk($sformatf("v%0d_p0_rdata", i), p0_rdata, vec[i].rd0);
            chk($sformatf("v%0d_p1_rdata", i), p1_rdata, vec[i].rd1);
            if (vec[i].rwe) begin
                chk($sformatf("v%0d_ram_wdata", i), ram_wdata, vec[i].g1 ? vec[i].d1 : vec[i].d0);
            end
            if (vec[i].g0 || vec[i].g1) begin
                chk($sformatf("v%0d_ram_width", i), {30'b0, ram_width}, vec[i].g1 ? 32'd1 : 32'd2);
                chk($sformatf("v%0d_ram_sext", i), {31'b0, ram_sext}, {31'b0, vec[i].g1});
            end
            step();
        end

        // Exclusive mode: p0 read granted in the last SHARED cycle, then p1 owns the RAM
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h10;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = 32'h14;
        excl_req = 1'b1;
        #2;
        $display("excl entry: p0_gnt=%0b excl_ack=%0b", p0_gnt, excl_ack);
        chk("excl_entry_p0_gnt", {31'b0, p0_gnt}, 32'd1);
        chk("excl_entry_ack", {31'b0, excl_ack}, 32'd0);
        step();
        p1_req = 1'b1;
        #2;
        $display("excl first: ack=%0b gnt=%0b%0b stall=%0b rv0=%0b rd0=%08h",
                 excl_ack, p0_gnt, p1_gnt, p0_stall, p0_rvalid, p0_rdata);
        chk("excl_inflight_rvalid", {31'b0, p0_rvalid}, 32'd1);
        chk("excl_inflight_rdata", p0_rdata, 32'hDEADBEEF);
        for (int k = 0; k < 4; k++) begin
            if (k == 3) excl_req = 1'b0;
            if (k != 0) #2;
            $display("excl cycle %0d: ack=%0b gnt=%0b%0b stall=%0b", k, excl_ack, p0_gnt, p1_gnt, p0_stall);
            chk($sformatf("excl%0d_ack", k), {31'b0, excl_ack}, 32'd1);
            chk($sformatf("excl%0d_p0_gnt", k), {31'b0, p0_gnt}, 32'd0);
            chk($sformatf("excl%0d_p1_gnt", k), {31'b0, p1_gnt}, 32'd1);
            chk($sformatf("excl%0d_stall", k), {31'b0, p0_stall}, 32'd1);
            step();
        end
        #2;
        $display("excl exit: ack=%0b gnt=%0b%0b", excl_ack, p0_gnt, p1_gnt);
        chk("exit_ack", {31'b0, excl_ack}, 32'd0);
        chk("exit_p0_gnt", {31'b0, p0_gnt}, 32'd1);
        chk("exit_p1_gnt", {31'b0, p1_gnt}, 32'd0);
        step();
        #2;
        $display("after exit: gnt=%0b%0b", p0_gnt, p1_gnt);
        chk("exit2_p0_gnt", {31'b0, p0_gnt}, 32'd0);
        chk("exit2_p1_gnt", {31'b0, p1_gnt}, 32'd1);
        step();

        // Reset right after a granted read: no rvalid, rdata cleared
        p1_req = 1'b0;
        p0_addr = 32'h24;
        #2;
        $display("abort read: p0_gnt=%0b", p0_gnt);
        chk("abort_p0_gnt", {31'b0, p0_gnt}, 32'd1);
        step();
        rst = 1'b1;
        #2;
        $display("abort in reset: rv0=%0b gnt0=%0b", p0_rvalid, p0_gnt);
        chk("abort_rvalid_in_rst", {31'b0, p0_rvalid}, 32'd0);
        chk("abort_gnt_in_rst", {31'b0, p0_gnt}, 32'd0);
        step();
        $display("abort after reset: rv0=%0b rd0=%08h", p0_rvalid, p0_rdata);
        chk("abort_rvalid", {31'b0, p0_rvalid}, 32'd0);
        chk("abort_rdata", p0_rdata, 32'h0);
        rst = 1'b0;
        p0_req = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 32, address width for both requesters and the RAM port.
REQ-002 Parameter: DATA_W, default 32, data width for both requesters and the RAM port.
REQ-003 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  in  1  reset, synchronous, active-high.
REQ-005 Port: p0_req / p1_req  in  1  access request; port 0 = CPU data side, port 1 = loader/debug.
REQ-006 Port: p0_we / p1_we  in  1  1 = write, 0 = read.
REQ-007 Port: p0_addr / p1_addr  in  ADDR_W  byte address.
REQ-008 Port: p0_wdata / p1_wdata  in  DATA_W  write data.
REQ-009 Port: p0_width / p1_width  in  2  access width code, passed unchanged to the RAM.
REQ-010 Port: p0_sext / p1_sext  in  1  load sign-extend flag, passed unchanged to the RAM.
REQ-011 Port: p0_gnt / p1_gnt  out  1  request accepted this cycle (combinational).
REQ-012 Port: p0_rvalid / p1_rvalid  out  1  read data valid, one cycle after a granted read.
REQ-013 Port: p0_rdata / p1_rdata  out  DATA_W  registered read data.
REQ-014 Port: p0_stall  out  1  p0_req & ~p0_gnt; drives CPU PC hold.
REQ-015 Port: excl_req  in  1  port 1 requests exclusive ownership of the RAM.
REQ-016 Port: excl_ack  out  1  registered; high while in state EXCL.
REQ-017 Port: ram_addr  out  ADDR_W, ram_wdata  out  DATA_W, ram_we  out  1, ram_width  out  2, ram_sext  out  1  RAM drive, muxed from the granted port.
REQ-018 Port: ram_rdata  in  DATA_W  RAM combinational read data for ram_addr.

Function
REQ-019 Grant rule: at most one gnt is high per cycle; a grant is issued only to a port whose req is high.
REQ-020 SHARED state, one requester: that requester is granted in the same cycle.
REQ-021 SHARED state, both requesting: the port other than last_gnt is granted; last_gnt is updated to the granted port on the clock edge.
REQ-022 Each grant completes one access in one cycle; back-to-back grants to either port are permitted with no idle cycle.
REQ-023 The requester holds req, we, addr, wdata, width and sext stable until it sees gnt high; the arbiter does not latch request fields.
REQ-024 RAM drive while a grant is active: ram_* equals the granted port's fields.
REQ-025 RAM drive with no grant: ram_we = 0 and ram_addr / ram_wdata hold the port 0 fields.
REQ-026 Read return: on a granted read, ram_rdata is captured into that port's rdata register, and that port's rvalid is high for exactly the next cycle.
REQ-027 Write response: a granted write never raises rvalid.
REQ-028 Hold: each rdata register holds its value until the next granted read to the same port.
REQ-029 FSM states are SHARED and EXCL.
REQ-030 SHARED -> EXCL on the clock edge where excl_req = 1.
REQ-031 EXCL -> SHARED on the clock edge where excl_req = 0.
REQ-032 In EXCL: p0_gnt = 0 regardless of p0_req, and p1 is granted whenever p1_req = 1.
REQ-033 In EXCL, last_gnt is not updated.
REQ-034 On entry to SHARED from EXCL, port 0 has priority for the first contended cycle.
REQ-035 Access in flight during a state change: it completes; rvalid of a read granted in the last SHARED cycle still asserts in the following cycle.

Reset
REQ-036 While rst = 1: both gnt = 0, ram_we = 0 and the RAM is never written.
REQ-037 On the edge with rst = 1: state = SHARED, last_gnt = port 1 (port 0 wins the first contention), excl_ack = 0, both rvalid = 0, both rdata = 0.
REQ-038 Reset asserted mid-operation: any read granted in the preceding cycle returns no rvalid.
REQ-039 First cycle after rst falls: normal arbitration applies.

Verification
REQ-040 Reset then p0 read addr 0x10 (RAM holds 0xDEADBEEF) -> p0_gnt same cycle; next cycle p0_rvalid = 1, p0_rdata = 0xDEADBEEF.
REQ-041 Both req every cycle for 4 cycles after reset -> grants in order p0, p1, p0, p1; p0_stall = 1 on cycles 2 and 4.
REQ-042 excl_req = 1, p0 and p1 both requesting -> after one edge excl_ack = 1, p1 granted every cycle, p0_stall stuck at 1; drop excl_req -> p0 granted first.
REQ-043 p1 write 0x12345678 to 0x20, then p0 read 0x20 -> p0_rdata = 0x12345678; p1_rvalid never asserts.
REQ-044 rst = 1 while p1_we = 1 and p1_req = 1 -> ram_we = 0; subsequent read of that address returns the old value.
REQ-045 p0 read granted, rst asserted the next cycle -> p0_rvalid = 0 and p0_rdata = 0.
